// File: rtl/nmea_field_parser.sv
// NMEA-0183 sentence parser: matches a 5-char address, splits the comma-separated
// payload into fixed-width field slots and optionally validates the *hh checksum.
module nmea_field_parser #(
  parameter logic [39:0]  SENT_ID     = 40'h4750474741,
  parameter int unsigned  NUM_FIELDS  = 8,
  parameter int unsigned  FIELD_CHARS = 10,
  parameter bit           CHECK_CSUM  = 1'b1,
  parameter int unsigned  MAX_LEN     = 82,
  localparam int unsigned LW          = $clog2(FIELD_CHARS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          uart_data,
  input  logic                                uart_valid,
  output logic [NUM_FIELDS*FIELD_CHARS*8-1:0] out_fields,
  output logic [NUM_FIELDS*LW-1:0]            out_lens,
  output logic [7:0]                          out_nfields,
  output logic                                out_trunc,
  output logic                                sent_valid,
  output logic                                sent_err,
  output logic [2:0]                          err_code
);

  localparam int unsigned FIW = (NUM_FIELDS > 1)  ? $clog2(NUM_FIELDS)  : 1;
  localparam int unsigned CIW = (FIELD_CHARS > 1) ? $clog2(FIELD_CHARS) : 1;
  localparam int unsigned BW  = $clog2(MAX_LEN + 1);

  localparam logic [7:0]    NF8   = 8'(NUM_FIELDS);
  localparam logic [LW-1:0] FC_L  = LW'(FIELD_CHARS);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_LEN);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  localparam logic [2:0] ERR_FORMAT   = 3'd1;
  localparam logic [2:0] ERR_BAD_HEX  = 3'd2;
  localparam logic [2:0] ERR_CSUM     = 3'd3;
  localparam logic [2:0] ERR_NO_CSUM  = 3'd4;
  localparam logic [2:0] ERR_TOO_LONG = 3'd5;

  typedef enum logic [2:0] {IDLE, ADDR, FIELD, CS_HI, CS_LO} state_t;

  state_t state, state_next;

  logic [NUM_FIELDS-1:0][FIELD_CHARS-1:0][7:0] work_fields;
  logic [NUM_FIELDS-1:0][LW-1:0]               work_lens;
  logic                                        trunc_flag;
  logic [7:0]                                  csum;
  logic [3:0]                                  cs_hi;
  logic [BW-1:0]                               byte_cnt;
  logic [7:0]                                  field_idx;
  logic [LW-1:0]                               char_idx;
  logic [2:0]                                  addr_cnt;

  logic       start, count_byte, addr_inc, csum_xor, comma, store, trunc_set;
  logic       hi_load, accept, err;
  logic [2:0] err_next;
  logic [7:0] id_byte;
  logic       hex_ok;
  logic [3:0] hex_val;

  // Address byte expected at position addr_cnt; first char sits in the MSB byte.
  always_comb begin
    id_byte = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (addr_cnt == 3'(i)) id_byte = SENT_ID[(4-i)*8 +: 8];
    end
  end

  always_comb begin
    hex_ok  = 1'b1;
    hex_val = '0;
    if (uart_data >= 8'h30 && uart_data <= 8'h39) begin
      hex_val = uart_data[3:0];
    end else if ((uart_data >= 8'h41 && uart_data <= 8'h46) ||
                 (uart_data >= 8'h61 && uart_data <= 8'h66)) begin
      hex_val = uart_data[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    count_byte = 1'b0;
    addr_inc   = 1'b0;
    csum_xor   = 1'b0;
    comma      = 1'b0;
    store      = 1'b0;
    trunc_set  = 1'b0;
    hi_load    = 1'b0;
    accept     = 1'b0;
    err        = 1'b0;
    err_next   = '0;
    if (uart_valid) begin
      if (uart_data == CH_DOLLAR) begin
        start      = 1'b1;
        state_next = ADDR;
      end else if (state != IDLE) begin
        if (byte_cnt >= MAX_B) begin
          err        = 1'b1;
          err_next   = ERR_TOO_LONG;
          state_next = IDLE;
        end else begin
          count_byte = 1'b1;
          case (state)
            ADDR: begin
              if (addr_cnt == 3'd5) begin
                if (uart_data == CH_COMMA) begin
                  csum_xor   = 1'b1;
                  state_next = FIELD;
                end else begin
                  err        = 1'b1;
                  err_next   = ERR_FORMAT;
                  state_next = IDLE;
                end
              end else if (uart_data == id_byte) begin
                addr_inc = 1'b1;
                csum_xor = 1'b1;
              end else begin
                state_next = IDLE;
              end
            end
            FIELD: begin
              if (uart_data == CH_STAR) begin
                if (CHECK_CSUM) begin
                  state_next = CS_HI;
                end else begin
                  accept     = 1'b1;
                  state_next = IDLE;
                end
              end else if (uart_data == CH_CR || uart_data == CH_LF) begin
                if (CHECK_CSUM) begin
                  err      = 1'b1;
                  err_next = ERR_NO_CSUM;
                end else begin
                  accept = 1'b1;
                end
                state_next = IDLE;
              end else begin
                csum_xor = 1'b1;
                if (uart_data == CH_COMMA)                         comma     = 1'b1;
                else if (field_idx < NF8 && char_idx < FC_L)       store     = 1'b1;
                else                                               trunc_set = 1'b1;
              end
            end
            CS_HI: begin
              if (hex_ok) begin
                hi_load    = 1'b1;
                state_next = CS_LO;
              end else begin
                err        = 1'b1;
                err_next   = ERR_BAD_HEX;
                state_next = IDLE;
              end
            end
            CS_LO: begin
              if (!hex_ok) begin
                err      = 1'b1;
                err_next = ERR_BAD_HEX;
              end else if ({cs_hi, hex_val} == csum) begin
                accept = 1'b1;
              end else begin
                err      = 1'b1;
                err_next = ERR_CSUM;
              end
              state_next = IDLE;
            end
            default: state_next = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      work_fields <= '0;
      work_lens   <= '0;
      trunc_flag  <= 1'b0;
      csum        <= '0;
      cs_hi       <= '0;
      byte_cnt    <= '0;
      field_idx   <= '0;
      char_idx    <= '0;
      addr_cnt    <= '0;
      out_fields  <= '0;
      out_lens    <= '0;
      out_nfields <= '0;
      out_trunc   <= 1'b0;
      sent_valid  <= 1'b0;
      sent_err    <= 1'b0;
      err_code    <= '0;
    end else begin
      state      <= state_next;
      sent_valid <= 1'b0;
      sent_err   <= 1'b0;
      if (start) begin
        work_fields <= '0;
        work_lens   <= '0;
        trunc_flag  <= 1'b0;
        csum        <= '0;
        cs_hi       <= '0;
        byte_cnt    <= BW'(1);
        field_idx   <= '0;
        char_idx    <= '0;
        addr_cnt    <= '0;
      end
      if (count_byte) byte_cnt <= byte_cnt + 1'b1;
      if (addr_inc)   addr_cnt <= addr_cnt + 3'd1;
      if (csum_xor)   csum     <= csum ^ uart_data;
      if (comma) begin
        if (field_idx != 8'hFF) field_idx <= field_idx + 8'd1;
        char_idx <= '0;
      end
      if (store) begin
        work_fields[field_idx[FIW-1:0]][char_idx[CIW-1:0]] <= uart_data;
        work_lens[field_idx[FIW-1:0]] <= char_idx + 1'b1;
        char_idx <= char_idx + 1'b1;
      end
      if (trunc_set) trunc_flag <= 1'b1;
      if (hi_load)   cs_hi      <= hex_val;
      // Working buffers are still intact here: the accepting byte never stores.
      if (accept) begin
        out_fields  <= work_fields;
        out_lens    <= work_lens;
        out_nfields <= (field_idx == 8'hFF) ? 8'hFF : field_idx + 8'd1;
        out_trunc   <= trunc_flag | (field_idx >= NF8);
        sent_valid  <= 1'b1;
      end
      if (err) begin
        sent_err <= 1'b1;
        err_code <= err_next;
      end
    end
  end

endmodule
